// File: rtl/eth_arb_pkg.sv
// rtl/eth_arb_pkg.sv - shared state, constants and round-robin pick helper for the TX frame arbiter
package eth_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    localparam int         MAX_PORTS   = 8;
    localparam int         PICK_W      = 3;
    localparam logic [7:0] ABORT_TDATA = 8'h00;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } rr_pick_t;

    // First set request scanning ptr, ptr+1, ... modulo nports; scanning
    // downwards lets the nearest candidate overwrite the farther ones.
    function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                         input logic [PICK_W-1:0]    ptr,
                                         input int                   nports);
        rr_pick_t res;
        int       idx;
        res = '0;
        for (int k = MAX_PORTS - 1; k >= 0; k--) begin
            if (k < nports) begin
                idx = int'(ptr) + k;
                if (idx >= nports) begin
                    idx = idx - nports;
                end
                if (req[idx[PICK_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = idx[PICK_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/eth_tx_frame_arbiter_if.sv
// rtl/eth_tx_frame_arbiter_if.sv - requester-side and MAC-side AXI-stream bundle of the TX frame arbiter
interface eth_tx_frame_arbiter_if #(
    parameter int PORTS = 4
);
    logic [PORTS*8-1:0] s_axis_tdata;
    logic [PORTS-1:0]   s_axis_tvalid;
    logic [PORTS-1:0]   s_axis_tready;
    logic [PORTS-1:0]   s_axis_tlast;
    logic [PORTS-1:0]   s_axis_tuser;

    logic [7:0]         m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic               m_axis_tlast;
    logic               m_axis_tuser;

    // The arbiter sinks the requester streams and sources the MAC stream.
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output m_axis_tready
    );

endinterface

// File: rtl/eth_tx_frame_arbiter.sv
// rtl/eth_tx_frame_arbiter.sv - frame-level round-robin arbiter with stall watchdog feeding the GMII MAC TX stream
module eth_rr_pick
    import eth_arb_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int IDX_W = 2
) (
    input  logic [PORTS-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);
    logic [MAX_PORTS-1:0] req_ext;
    logic [PICK_W-1:0]    ptr_ext;
    rr_pick_t             pick;
    logic                 unused_pick_hi;

    always_comb begin
        req_ext              = '0;
        req_ext[PORTS-1:0]   = req_i;
        ptr_ext              = '0;
        ptr_ext[IDX_W-1:0]   = ptr_i;
        pick                 = rr_pick(req_ext, ptr_ext, PORTS);
    end

    assign found_o        = pick.found;
    assign idx_o          = pick.idx[IDX_W-1:0];
    assign unused_pick_hi = ^pick.idx;
endmodule

module eth_tx_frame_arbiter
    import eth_arb_pkg::*;
#(
    parameter int  PORTS          = 4,
    parameter int  TIMEOUT_CYCLES = 1024,
    parameter int  CNT_W          = 11,
    localparam int IDX_W          = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    eth_tx_frame_arbiter_if.slave  axis,
    input  logic [PORTS-1:0]       cfg_port_enable,
    output logic                   stat_busy,
    output logic [IDX_W-1:0]       stat_grant_port,
    output logic                   stat_abort,
    output logic [IDX_W-1:0]       stat_abort_port
);
    localparam logic [CNT_W-1:0] STALL_LIMIT =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(PORTS - 1);

    arb_state_e       state_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] grant_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             stat_abort_q;
    logic [IDX_W-1:0] stat_abort_port_q;

    logic [PORTS-1:0] req;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [7:0]       g_tdata;
    logic             g_tvalid;
    logic             g_tlast;
    logic             g_tuser;
    logic [IDX_W-1:0] next_ptr;

    assign req = axis.s_axis_tvalid & cfg_port_enable;

    eth_rr_pick #(
        .PORTS (PORTS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        g_tdata = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                g_tdata = axis.s_axis_tdata[i*8 +: 8];
            end
        end
    end

    assign g_tvalid = axis.s_axis_tvalid[grant_q];
    assign g_tlast  = axis.s_axis_tlast[grant_q];
    assign g_tuser  = axis.s_axis_tuser[grant_q];
    assign next_ptr = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;

    // Outputs decode straight from state_q so reset drops them without a clock.
    always_comb begin
        axis.m_axis_tdata  = '0;
        axis.m_axis_tvalid = 1'b0;
        axis.m_axis_tlast  = 1'b0;
        axis.m_axis_tuser  = 1'b0;
        axis.s_axis_tready = '0;
        case (state_q)
            XFER: begin
                axis.m_axis_tdata           = g_tdata;
                axis.m_axis_tvalid          = g_tvalid;
                axis.m_axis_tlast           = g_tlast;
                axis.m_axis_tuser           = g_tuser;
                axis.s_axis_tready[grant_q] = axis.m_axis_tready;
            end
            ABORT: begin
                axis.m_axis_tdata  = ABORT_TDATA;
                axis.m_axis_tvalid = 1'b1;
                axis.m_axis_tlast  = 1'b1;
                axis.m_axis_tuser  = 1'b1;
            end
            DRAIN: begin
                axis.s_axis_tready[grant_q] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            rr_ptr_q          <= '0;
            grant_q           <= '0;
            stall_cnt_q       <= '0;
            stat_abort_q      <= 1'b0;
            stat_abort_port_q <= '0;
        end else begin
            stat_abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q     <= pick_idx;
                        stall_cnt_q <= '0;
                        state_q     <= XFER;
                    end
                end
                XFER: begin
                    // Only a silent source counts; MAC backpressure keeps the count clear.
                    if (!g_tvalid) begin
                        if ((TIMEOUT_CYCLES != 0) && (stall_cnt_q == STALL_LIMIT)) begin
                            state_q <= ABORT;
                        end else begin
                            stall_cnt_q <= stall_cnt_q + 1'b1;
                        end
                    end else begin
                        stall_cnt_q <= '0;
                        if (axis.m_axis_tready && g_tlast) begin
                            rr_ptr_q <= next_ptr;
                            state_q  <= IDLE;
                        end
                    end
                end
                ABORT: begin
                    if (axis.m_axis_tready) begin
                        stat_abort_q      <= 1'b1;
                        stat_abort_port_q <= grant_q;
                        state_q           <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (g_tvalid && g_tlast) begin
                        rr_ptr_q <= next_ptr;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stat_busy       = (state_q != IDLE);
    assign stat_grant_port = grant_q;
    assign stat_abort      = stat_abort_q;
    assign stat_abort_port = stat_abort_port_q;
endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// tb/tb_eth_tx_frame_arbiter.sv - randomized directed bench for eth_tx_frame_arbiter with a frame-queue reference model
module tb_eth_tx_frame_arbiter;
    localparam int PORTS   = 4;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [PORTS-1:0] cfg_port_enable;
    logic             stat_busy;
    logic [1:0]       stat_grant_port;
    logic             stat_abort;
    logic [1:0]       stat_abort_port;

    eth_tx_frame_arbiter_if #(.PORTS(PORTS)) axis_if ();

    eth_tx_frame_arbiter #(
        .PORTS          (PORTS),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .axis            (axis_if),
        .cfg_port_enable (cfg_port_enable),
        .stat_busy       (stat_busy),
        .stat_grant_port (stat_grant_port),
        .stat_abort      (stat_abort),
        .stat_abort_port (stat_abort_port)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] data; logic last; logic user; } beat_t;
    typedef struct { logic [7:0] data; logic last; logic user; int port; int cyc; } obs_t;

    beat_t src_q [PORTS][$];
    beat_t mdl_q [PORTS][$];
    obs_t  out_q [$];
    obs_t  exp_q [$];
    bit    hs      [PORTS];
    int    gap_cnt [PORTS];
    int    mdl_ptr;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    gaps_en;
    int    ready_pct;
    int    abort_cnt = 0;
    int    abort_cyc = -1;
    int    abort_port_seen = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < PORTS; p++) begin
            if (src_q[p].size() > 0 && gap_cnt[p] == 0) begin
                axis_if.s_axis_tvalid[p]       = 1'b1;
                axis_if.s_axis_tdata[p*8 +: 8] = src_q[p][0].data;
                axis_if.s_axis_tlast[p]        = src_q[p][0].last;
                axis_if.s_axis_tuser[p]        = src_q[p][0].user;
            end else begin
                axis_if.s_axis_tvalid[p]       = 1'b0;
                axis_if.s_axis_tdata[p*8 +: 8] = 8'h00;
                axis_if.s_axis_tlast[p]        = 1'b0;
                axis_if.s_axis_tuser[p]        = 1'b0;
            end
        end
    endtask

    // One clock: sources advance after the edge, everything is observed at the falling edge.
    task automatic step();
        beat_t b;
        obs_t  o;
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < PORTS; p++) begin
            if (hs[p]) begin
                b = src_q[p].pop_front();
                if (gaps_en && !b.last && src_q[p].size() > 0 && $urandom_range(0, 2) == 0)
                    gap_cnt[p] = $urandom_range(1, 3);
            end else if (gap_cnt[p] > 0) begin
                gap_cnt[p]--;
            end
            hs[p] = 1'b0;
        end
        axis_if.m_axis_tready = ($urandom_range(0, 99) < ready_pct);
        drive();
        @(negedge clk);
        for (int p = 0; p < PORTS; p++)
            hs[p] = axis_if.s_axis_tvalid[p] & axis_if.s_axis_tready[p];
        if (axis_if.m_axis_tvalid && axis_if.m_axis_tready) begin
            o.data = axis_if.m_axis_tdata;
            o.last = axis_if.m_axis_tlast;
            o.user = axis_if.m_axis_tuser;
            o.port = int'(stat_grant_port);
            o.cyc  = cyc;
            out_q.push_back(o);
        end
        if (stat_abort) begin
            abort_cnt++;
            abort_cyc       = cyc;
            abort_port_seen = int'(stat_abort_port);
        end
    endtask

    task automatic push_frame(input int p, input int len, input bit with_last, input bit to_model);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = 8'($urandom);
            b.last = with_last && (i == len - 1);
            b.user = b.last && ($urandom_range(0, 3) == 0);
            src_q[p].push_back(b);
            if (to_model) mdl_q[p].push_back(b);
        end
    endtask

    // Whole frames leave in round-robin order among enabled ports with work pending.
    task automatic mdl_run(input logic [PORTS-1:0] en);
        int    pick;
        int    q;
        beat_t b;
        obs_t  o;
        forever begin
            pick = -1;
            for (int k = 0; k < PORTS; k++) begin
                q = (mdl_ptr + k) % PORTS;
                if (pick < 0 && en[q] && mdl_q[q].size() > 0) pick = q;
            end
            if (pick < 0) break;
            do begin
                b      = mdl_q[pick].pop_front();
                o.data = b.data;
                o.last = b.last;
                o.user = b.user;
                o.port = pick;
                o.cyc  = 0;
                exp_q.push_back(o);
            end while (!b.last);
            mdl_ptr = (pick + 1) % PORTS;
        end
    endtask

    task automatic run_idle(input string tag, input int budget, input logic [PORTS-1:0] ignore);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            done = !stat_busy && !axis_if.m_axis_tvalid;
            for (int p = 0; p < PORTS; p++)
                if (!ignore[p] && src_q[p].size() > 0) done = 1'b0;
        end
        chk({tag, " completes"}, done, 1);
        repeat (3) step();
    endtask

    task automatic check_stream(input string tag, input bit exact_gap);
        int n;
        int bad;
        int bad_gap;
        int g;
        chk({tag, " beat count"}, out_q.size(), exp_q.size());
        n   = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        bad = 0;
        bad_gap = 0;
        for (int i = 0; i < n; i++) begin
            if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last ||
                out_q[i].user !== exp_q[i].user || out_q[i].port != exp_q[i].port)
                bad++;
            if (i > 0 && out_q[i-1].last) begin
                g = out_q[i].cyc - out_q[i-1].cyc;
                if (g < 2 || (exact_gap && g != 2)) bad_gap++;
            end
        end
        chk({tag, " beats differing from model"}, bad, 0);
        chk({tag, " bad inter-frame gaps"}, bad_gap, 0);
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            src_q[p].delete();
            mdl_q[p].delete();
            hs[p]      = 1'b0;
            gap_cnt[p] = 0;
        end
        out_q.delete();
        exp_q.delete();
        mdl_ptr = 0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int aborts_before;
        obs_t o;

        rst_n                 = 1'b0;
        cfg_port_enable       = 4'hF;
        axis_if.m_axis_tready = 1'b0;
        gaps_en               = 1'b0;
        ready_pct             = 100;
        mdl_ptr               = 0;
        for (int p = 0; p < PORTS; p++) begin
            hs[p]      = 1'b0;
            gap_cnt[p] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #2;
        chk("reset m_tvalid", axis_if.m_axis_tvalid, 0);
        chk("reset m_tlast", axis_if.m_axis_tlast, 0);
        chk("reset m_tuser", axis_if.m_axis_tuser, 0);
        chk("reset m_tdata", axis_if.m_axis_tdata, 0);
        chk("reset s_tready", axis_if.s_axis_tready, 0);
        chk("reset stat_busy", stat_busy, 0);
        chk("reset stat_grant_port", stat_grant_port, 0);
        chk("reset stat_abort", stat_abort, 0);
        chk("reset stat_abort_port", stat_abort_port, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two 64-byte frames queued together, random source gaps and MAC backpressure.
        gaps_en   = 1'b1;
        ready_pct = 70;
        push_frame(0, 64, 1, 1);
        push_frame(2, 64, 1, 1);
        mdl_run(4'hF);
        run_idle("t1", 3000, 4'h0);
        check_stream("t1", 1'b0);

        // All ports back-to-back with 3-byte frames from a fresh pointer.
        do_reset();
        gaps_en   = 1'b0;
        ready_pct = 100;
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < PORTS; p++)
                push_frame(p, 3, 1, 1);
        mdl_run(4'hF);
        run_idle("t2", 500, 4'h0);
        check_stream("t2", 1'b1);

        // Random mix including single-beat frames.
        gaps_en   = 1'b1;
        ready_pct = 60;
        for (int f = 0; f < 14; f++)
            push_frame($urandom_range(0, PORTS - 1), $urandom_range(1, 20), 1, 1);
        push_frame(3, 1, 1, 1);
        mdl_run(4'hF);
        run_idle("rnd", 4000, 4'h0);
        check_stream("rnd", 1'b0);

        // Source stalls after 10 bytes: watchdog abort, then the tail is drained silently.
        gaps_en   = 1'b0;
        ready_pct = 100;
        aborts_before = abort_cnt;
        push_frame(1, 10, 0, 0);
        for (int i = 0; i < 10; i++) begin
            o.data = src_q[1][i].data;
            o.last = 1'b0;
            o.user = 1'b0;
            o.port = 1;
            o.cyc  = 0;
            exp_q.push_back(o);
        end
        o.data = 8'h00;
        o.last = 1'b1;
        o.user = 1'b1;
        exp_q.push_back(o);
        n = 0;
        while (abort_cnt == aborts_before && n < 200) begin
            step();
            n++;
        end
        chk("t3 abort pulses", abort_cnt - aborts_before, 1);
        chk("t3 abort port", abort_port_seen, 1);
        chk("t3 stall length before abort beat",
            (out_q.size() >= 11) ? out_q[10].cyc - out_q[9].cyc : -1, TIMEOUT + 1);
        chk("t3 abort pulse follows abort beat",
            (out_q.size() >= 11) ? abort_cyc - out_q[10].cyc : -1, 1);
        step();
        chk("t3 abort is a single-cycle pulse", stat_abort, 0);
        chk("t3 busy while draining", stat_busy, 1);
        check_stream("t3", 1'b0);
        mdl_ptr = 2;
        push_frame(1, 5, 1, 0);
        run_idle("t3 drain", 100, 4'h0);
        chk("t3 drained beats reach MAC", out_q.size(), 0);
        chk("t3 no extra abort", abort_cnt - aborts_before, 1);

        // Long MAC backpressure mid-frame must not trip the watchdog.
        aborts_before = abort_cnt;
        push_frame(0, 20, 1, 1);
        mdl_run(4'hF);
        n = 0;
        while (out_q.size() < 5 && n < 100) begin
            step();
            n++;
        end
        ready_pct = 0;
        repeat (2000) step();
        chk("t4 beats during backpressure", out_q.size(), 5);
        chk("t4 busy during backpressure", stat_busy, 1);
        chk("t4 no abort", abort_cnt - aborts_before, 0);
        ready_pct = 100;
        run_idle("t4", 200, 4'h0);
        check_stream("t4", 1'b0);

        // Disabled port is never granted; disabling mid-frame lets the frame finish.
        cfg_port_enable = 4'b1011;
        push_frame(2, 8, 1, 1);
        push_frame(0, 8, 1, 1);
        push_frame(3, 8, 1, 1);
        mdl_run(4'b1011);
        run_idle("t5a", 500, 4'b0100);
        check_stream("t5a", 1'b0);
        chk("t5a port 2 untouched", src_q[2].size(), 8);
        push_frame(0, 20, 1, 1);
        mdl_run(4'b1011);
        n = 0;
        while (out_q.size() < 3 && n < 100) begin
            step();
            n++;
        end
        cfg_port_enable = 4'b1010;
        push_frame(1, 6, 1, 1);
        push_frame(0, 6, 1, 1);
        mdl_run(4'b1010);
        run_idle("t5b", 500, 4'b0101);
        check_stream("t5b", 1'b0);
        chk("t5b port 0 not regranted", src_q[0].size(), 6);

        // Asynchronous reset mid-frame, then arbitration restarts at port 0.
        do_reset();
        cfg_port_enable = 4'hF;
        push_frame(1, 30, 1, 1);
        n = 0;
        while (out_q.size() < 5 && n < 100) begin
            step();
            n++;
        end
        chk("t6 frame in flight", axis_if.m_axis_tvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 async m_tvalid", axis_if.m_axis_tvalid, 0);
        chk("t6 async s_tready", axis_if.s_axis_tready, 0);
        chk("t6 async busy", stat_busy, 0);
        do_reset();
        push_frame(3, 4, 1, 1);
        push_frame(0, 4, 1, 1);
        mdl_run(4'hF);
        run_idle("t6", 200, 4'h0);
        check_stream("t6", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
